// File: rtl/wasm_stack.sv
`default_nettype none
// ============================================================================
// Module   : wasm_stack
// Purpose  : Operand stack for the WebAssembly execution core. It sits between
//            the decoder/ALU and operand memory and supports push, pop and
//            replace. It also supports binary-op collapse, multi-entry drop,
//            and indexed peek and write.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous active-low reset
//            op        - 0 NONE,1 PUSH,2 POP,3 REPLACE,4 BINOP,5 DROP,6 PEEK,7 SET
//            data      - write operand (PUSH/REPLACE/BINOP/SET)
//            index     - depth operand (0 = top); entry count for DROP
//            tos, nos  - registered top / next-of-stack (nos = 0 if count < 2)
//            peek_data - result of last successful PEEK
//            count     - occupancy 0..2**DEPTH
//            status    - 0 NONE,1 EMPTY,2 FULL,3 OVERFLOW,4 UNDERFLOW,5 BADINDEX
//            error     - sticky failure flag, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
module wasm_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [DEPTH:0]   index,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [WIDTH-1:0] peek_data,
  output logic [DEPTH:0]   count,
  output logic [2:0]       status,
  output logic             error
);

  localparam int             MAX    = 2 ** DEPTH;
  localparam logic [DEPTH:0] C_MAX  = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] C_ZERO = '0;
  localparam logic [DEPTH:0] C_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] C_TWO  = (DEPTH+1)'(2);

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_BINOP   = 3'd4;
  localparam logic [2:0] OP_DROP    = 3'd5;
  localparam logic [2:0] OP_PEEK    = 3'd6;
  localparam logic [2:0] OP_SET     = 3'd7;

  localparam logic [2:0] ST_NONE      = 3'd0;
  localparam logic [2:0] ST_EMPTY     = 3'd1;
  localparam logic [2:0] ST_FULL      = 3'd2;
  localparam logic [2:0] ST_OVERFLOW  = 3'd3;
  localparam logic [2:0] ST_UNDERFLOW = 3'd4;
  localparam logic [2:0] ST_BADINDEX  = 3'd5;

  // Storage is deliberately not reset; only count decides what is visible.
  logic [WIDTH-1:0] mem_q [MAX];

  logic [DEPTH:0]   count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [WIDTH-1:0] peek_q, peek_d;
  logic [2:0]       status_q, status_d;
  logic             error_q, error_d;

  logic             wr_en;
  logic [DEPTH-1:0] wr_addr;
  logic             fail;
  logic [2:0]       fail_code;

  // Low DEPTH bits of modular address arithmetic; the results are only used
  // once the legality check has guaranteed they are in range.
  logic [DEPTH-1:0] top_addr;   // c-1
  logic [DEPTH-1:0] sec_addr;   // c-2
  logic [DEPTH-1:0] slot_addr;  // c-1-index
  logic [DEPTH-1:0] tos_addr;   // count_d-1
  logic [DEPTH-1:0] nos_addr;   // count_d-2

  always_comb begin
    top_addr  = count_q[DEPTH-1:0] - DEPTH'(1);
    sec_addr  = count_q[DEPTH-1:0] - DEPTH'(2);
    slot_addr = count_q[DEPTH-1:0] - DEPTH'(1) - index[DEPTH-1:0];
  end

  always_comb begin
    count_d   = count_q;
    tos_d     = tos_q;
    nos_d     = nos_q;
    peek_d    = peek_q;
    status_d  = status_q;
    error_d   = error_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    fail      = 1'b0;
    fail_code = ST_NONE;
    tos_addr  = '0;
    nos_addr  = '0;

    case (op)
      OP_PUSH: begin
        if (count_q < C_MAX) begin
          wr_en   = 1'b1;
          wr_addr = count_q[DEPTH-1:0];
          count_d = count_q + C_ONE;
        end else begin
          fail      = 1'b1;
          fail_code = ST_OVERFLOW;
        end
      end
      OP_POP: begin
        if (count_q >= C_ONE) begin
          count_d = count_q - C_ONE;
        end else begin
          fail      = 1'b1;
          fail_code = ST_UNDERFLOW;
        end
      end
      OP_REPLACE: begin
        if (count_q >= C_ONE) begin
          wr_en   = 1'b1;
          wr_addr = top_addr;
        end else begin
          fail      = 1'b1;
          fail_code = ST_UNDERFLOW;
        end
      end
      OP_BINOP: begin
        // Result overwrites the lower operand; the upper one is discarded.
        if (count_q >= C_TWO) begin
          wr_en   = 1'b1;
          wr_addr = sec_addr;
          count_d = count_q - C_ONE;
        end else begin
          fail      = 1'b1;
          fail_code = ST_UNDERFLOW;
        end
      end
      OP_DROP: begin
        if (index <= count_q) begin
          count_d = count_q - index;
        end else begin
          fail      = 1'b1;
          fail_code = ST_UNDERFLOW;
        end
      end
      OP_PEEK: begin
        if (index < count_q) begin
          peek_d = mem_q[slot_addr];
        end else begin
          fail      = 1'b1;
          fail_code = ST_BADINDEX;
        end
      end
      OP_SET: begin
        if (index < count_q) begin
          wr_en   = 1'b1;
          wr_addr = slot_addr;
        end else begin
          fail      = 1'b1;
          fail_code = ST_BADINDEX;
        end
      end
      default: begin
        // OP_NONE: always legal, storage untouched.
      end
    endcase

    if (fail) begin
      status_d = fail_code;
      error_d  = 1'b1;
    end else begin
      // tos/nos are taken from the post-write view of storage so that a
      // write to either of the top two slots shows up on the next cycle.
      tos_addr = count_d[DEPTH-1:0] - DEPTH'(1);
      nos_addr = count_d[DEPTH-1:0] - DEPTH'(2);
      if (count_d >= C_ONE) begin
        tos_d = (wr_en && (wr_addr == tos_addr)) ? data : mem_q[tos_addr];
      end
      if (count_d >= C_TWO) begin
        nos_d = (wr_en && (wr_addr == nos_addr)) ? data : mem_q[nos_addr];
      end else begin
        nos_d = '0;
      end
      if (count_d == C_ZERO) begin
        status_d = ST_EMPTY;
      end else if (count_d == C_MAX) begin
        status_d = ST_FULL;
      end else begin
        status_d = ST_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      tos_q    <= '0;
      nos_q    <= '0;
      peek_q   <= '0;
      status_q <= ST_EMPTY;
      error_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      tos_q    <= tos_d;
      nos_q    <= nos_d;
      peek_q   <= peek_d;
      status_q <= status_d;
      error_q  <= error_d;
    end
  end

  assign tos       = tos_q;
  assign nos       = nos_q;
  assign peek_data = peek_q;
  assign count     = count_q;
  assign status    = status_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_wasm_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_wasm_stack
// Purpose  : Self-checking bench for wasm_stack (WIDTH=8, DEPTH=2, MAX=4).
//            A queue-based reference model tracks the stack contents. Directed
//            steps come first, followed by random operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wasm_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int MAX   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic [DEPTH:0]   index;
  logic [WIDTH-1:0] tos, nos, peek_data;
  logic [DEPTH:0]   count;
  logic [2:0]       status;
  logic             error;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_tos, m_nos, m_peek;
  logic [2:0]       m_status;
  logic             m_error;

  wasm_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .data      (data),
    .index     (index),
    .tos       (tos),
    .nos       (nos),
    .peek_data (peek_data),
    .count     (count),
    .status    (status),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    q.delete();
    m_tos    = '0;
    m_nos    = '0;
    m_peek   = '0;
    m_status = 3'd1;
    m_error  = 1'b0;
  endfunction

  function automatic void model_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input int idx);
    int         c;
    bit         bad;
    logic [2:0] code;
    logic [WIDTH-1:0] junk;
    c    = q.size();
    bad  = 1'b0;
    code = 3'd0;
    case (o)
      3'd1: if (c < MAX) q.push_back(d); else begin bad = 1'b1; code = 3'd3; end
      3'd2: if (c >= 1) junk = q.pop_back(); else begin bad = 1'b1; code = 3'd4; end
      3'd3: if (c >= 1) q[c-1] = d; else begin bad = 1'b1; code = 3'd4; end
      3'd4: if (c >= 2) begin junk = q.pop_back(); q[c-2] = d; end
            else begin bad = 1'b1; code = 3'd4; end
      3'd5: if (idx <= c) begin for (int k = 0; k < idx; k++) junk = q.pop_back(); end
            else begin bad = 1'b1; code = 3'd4; end
      3'd6: if (idx < c) m_peek = q[c-1-idx]; else begin bad = 1'b1; code = 3'd5; end
      3'd7: if (idx < c) q[c-1-idx] = d; else begin bad = 1'b1; code = 3'd5; end
      default: ;
    endcase
    if (bad) begin
      m_status = code;
      m_error  = 1'b1;
    end else begin
      c = q.size();
      if (c >= 1) m_tos = q[c-1];
      m_nos    = (c >= 2) ? q[c-2] : '0;
      m_status = (c == 0) ? 3'd1 : ((c == MAX) ? 3'd2 : 3'd0);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count"},  32'(count),     32'(q.size()));
    chk({tag, " tos"},    32'(tos),       32'(m_tos));
    chk({tag, " nos"},    32'(nos),       32'(m_nos));
    chk({tag, " peek"},   32'(peek_data), 32'(m_peek));
    chk({tag, " status"}, 32'(status),    32'(m_status));
    chk({tag, " error"},  32'(error),     32'(m_error));
  endtask

  // Drive one op, let it be captured on the next rising edge, then compare.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input logic [DEPTH:0] i, input string tag);
    op    = o;
    data  = d;
    index = i;
    @(posedge clk);
    model_op(o, d, int'(i));
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    op    = 3'd0;
    data  = '0;
    index = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1. underflow on empty stack, error sticky
    do_op(3'd2, 8'h00, 3'd0, "pop_empty");
    chk("pop_empty status_lit", 32'(status), 32'd4);
    do_op(3'd0, 8'h00, 3'd0, "none_after");
    chk("none_after error_lit", 32'(error), 32'd1);

    // 2. fill, then overflow
    do_op(3'd1, 8'h10, 3'd0, "push10");
    do_op(3'd1, 8'h20, 3'd0, "push20");
    do_op(3'd1, 8'h30, 3'd0, "push30");
    do_op(3'd1, 8'h40, 3'd0, "push40");
    chk("full tos_lit", 32'(tos), 32'h40);
    chk("full nos_lit", 32'(nos), 32'h30);
    do_op(3'd1, 8'h50, 3'd0, "push_ovf");
    chk("push_ovf status_lit", 32'(status), 32'd3);

    // 3. peek deepest, then bad index
    do_op(3'd6, 8'h00, 3'd3, "peek3");
    chk("peek3 lit", 32'(peek_data), 32'h10);
    do_op(3'd6, 8'h00, 3'd4, "peek4_bad");
    chk("peek4 status_lit", 32'(status), 32'd5);

    // 4. binop, set under top, peek bottom
    do_op(3'd4, 8'h99, 3'd0, "binop");
    chk("binop nos_lit", 32'(nos), 32'h20);
    do_op(3'd7, 8'h07, 3'd1, "set1");
    chk("set1 nos_lit", 32'(nos), 32'h07);
    do_op(3'd6, 8'h00, 3'd2, "peek2");

    // 5. drop to empty, then underflows
    do_op(3'd5, 8'h00, 3'd3, "drop3");
    do_op(3'd5, 8'h00, 3'd1, "drop_ovr");
    do_op(3'd3, 8'h05, 3'd0, "replace_empty");

    // Drop MAX from a full stack, wide out-of-range index values
    for (int k = 0; k < MAX; k++) do_op(3'd1, 8'(8'hA0 + k), 3'd0, "refill");
    do_op(3'd6, 8'h00, 3'd7, "peek7_bad");
    do_op(3'd5, 8'h00, 3'd4, "drop_max");
    chk("drop_max count_lit", 32'(count), 32'd0);

    // 6. asynchronous reset mid-cycle with an in-flight push
    do_op(3'd1, 8'h11, 3'd0, "pre_rst_a");
    do_op(3'd1, 8'h22, 3'd0, "pre_rst_b");
    op   = 3'd1;
    data = 8'h33;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst status_lit", 32'(status), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_op(3'd1, 8'h0A, 3'd0, "post_rst_push");
    chk("post_rst tos_lit", 32'(tos), 32'h0A);

    // Random phase, biased toward pushes so the stack visits all depths
    for (int n = 0; n < 300; n++) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      do_op(ro, 8'($urandom), 3'($urandom_range(0, 7)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
